writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin ALU/MEM result arbiter feeding a writeback FIFO
// that drives a single-cycle register-file write stage.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 32,
  parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [NUM_REGS_LOG-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [NUM_REGS_LOG-1:0]  mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [NUM_REGS_LOG-1:0]  write_reg,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [NUM_REGS-1:0]      pending,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [NUM_REGS_LOG-1:0] q_rd [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PW-1:0] wp, rp;
  logic pri_alu, grant_alu, grant_mem, open, push, pop;
  logic [NUM_REGS_LOG-1:0] in_rd;
  logic [DATA_WIDTH-1:0] in_data;
  always_comb begin
    grant_alu = alu_valid && (!mem_valid || pri_alu);
    grant_mem = mem_valid && !grant_alu;
    open = reset && !flush && (count != FULL);
    alu_ready = grant_alu && open;
    mem_ready = grant_mem && open;
    in_rd = mem_ready ? mem_rd : alu_rd;
    in_data = mem_ready ? mem_data : alu_data;
    push = (alu_ready || mem_ready) && (in_rd != '0);
    pop = count != '0;
  end
  // occupancy window starts at rp and spans count entries, wrapping modulo DEPTH
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(count)) pending[q_rd[rp + PW'(i)]] = 1'b1;
    pending[write_reg] = 1'b1;
    pending[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) begin
      q_rd[wp] <= in_rd;
      q_data[wp] <= in_data;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      write_reg <= '0;
      write_data <= '0;
      pri_alu <= 1'b1;
    end else if (flush) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      write_reg <= '0;
      write_data <= '0;
    end else begin
      if (alu_ready || mem_ready) pri_alu <= mem_ready;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      write_reg <= pop ? q_rd[rp] : '0;
      write_data <= pop ? q_data[rp] : '0;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule
